alu_exec_ctrl: RTL and testbench

//  Execute-stage controller directly upstream of the 16-bit ripple ALU (16 x 1-bit slices).

---
 rtl/alu_exec_ctrl_pkg.sv | 30 +++
 rtl/alu_exec_ctrl_decode.sv | 46 ++++
 rtl/alu_exec_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared opcode, ALU-op, FSM-state and flag-index definitions for the
// execute-stage controller and its opcode decoder.
package alu_exec_ctrl_pkg;

  localparam logic [3:0] OPC_ADD  = 4'd0;
  localparam logic [3:0] OPC_SUB  = 4'd1;
  localparam logic [3:0] OPC_AND  = 4'd2;
  localparam logic [3:0] OPC_OR   = 4'd3;
  localparam logic [3:0] OPC_XOR  = 4'd4;
  localparam logic [3:0] OPC_NOR  = 4'd5;
  localparam logic [3:0] OPC_NAND = 4'd6;
  localparam logic [3:0] OPC_SLT  = 4'd7;

  localparam logic [2:0] ALU_OP_AND = 3'd0;
  localparam logic [2:0] ALU_OP_OR  = 3'd1;
  localparam logic [2:0] ALU_OP_ADD = 3'd2;
  localparam logic [2:0] ALU_OP_XOR = 3'd3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_ctrl_decode.sv
// Combinational opcode decoder: maps the 4-bit opcode onto the ripple ALU
// control lines and flags opcodes 8..15 as illegal.
module alu_exec_ctrl_decode
  import alu_exec_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       ainvert_o,
  output logic       bnegate_o,
  output logic [2:0] op_o,
  output logic       illegal_o
);

  always_comb begin
    ainvert_o = 1'b0;
    bnegate_o = 1'b0;
    op_o      = ALU_OP_AND;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_ADD: op_o = ALU_OP_ADD;
      OPC_SUB: begin
        bnegate_o = 1'b1;
        op_o      = ALU_OP_ADD;
      end
      OPC_AND: op_o = ALU_OP_AND;
      OPC_OR:  op_o = ALU_OP_OR;
      OPC_XOR: op_o = ALU_OP_XOR;
      // NOR/NAND come from De Morgan on the inverted operands
      OPC_NOR: begin
        ainvert_o = 1'b1;
        bnegate_o = 1'b1;
        op_o      = ALU_OP_AND;
      end
      OPC_NAND: begin
        ainvert_o = 1'b1;
        bnegate_o = 1'b1;
        op_o      = ALU_OP_OR;
      end
      OPC_SLT: begin
        bnegate_o = 1'b1;
        op_o      = ALU_OP_ADD;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: drives the external ripple ALU with registered
// operands, waits the settle time, then presents a write-back beat.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wb_en,
  output logic [2:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             live_q;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             ainv_q, ainv_d, bneg_q, bneg_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       opc_q, opc_d;
  logic [2:0]       rd_q, rd_d;
  logic             wb_en_q, wb_en_d;
  logic [2:0]       wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             dec_ainv, dec_bneg, dec_illegal;
  logic [2:0]       dec_op;
  logic             accept, flush_act, capture, release_beat;

  alu_exec_ctrl_decode u_decode (
    .opcode_i  (in_opcode),
    .ainvert_o (dec_ainv),
    .bnegate_o (dec_bneg),
    .op_o      (dec_op),
    .illegal_o (dec_illegal)
  );

  assign accept       = in_valid && in_ready;
  assign flush_act    = flush && (state_q != S_IDLE);
  assign capture      = (state_q == S_EXEC) && (cnt_q == 4'd0) && !flush;
  assign release_beat = (state_q == S_DONE) && out_ready;

  // live_q keeps in_ready low while reset is asserted and for the first edge after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (dec_illegal) begin
            state_d = S_DONE;
          end else begin
            state_d = S_EXEC;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_EXEC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && live_q;
    out_valid = (state_q == S_DONE);
  end

  logic             a_msb, b_msb, r_msb, is_add, is_sub_like;
  logic             n_flag, c_flag, v_flag;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       flags_calc;

  // SLT reuses the subtraction; only the written data is replaced by N^V
  always_comb begin
    a_msb       = a_q[WIDTH-1];
    b_msb       = b_q[WIDTH-1];
    r_msb       = alu_result[WIDTH-1];
    is_add      = (opc_q == OPC_ADD);
    is_sub_like = (opc_q == OPC_SUB) || (opc_q == OPC_SLT);
    n_flag      = r_msb;
    c_flag      = (is_add || is_sub_like) && alu_cout;
    if (is_add)
      v_flag = (a_msb == b_msb) && (r_msb != a_msb);
    else if (is_sub_like)
      v_flag = (a_msb != b_msb) && (r_msb != a_msb);
    else
      v_flag = 1'b0;
    res_data = alu_result;
    if (opc_q == OPC_SLT) begin
      res_data    = '0;
      res_data[0] = n_flag ^ v_flag;
    end
    flags_calc         = 4'd0;
    flags_calc[FLAG_N] = n_flag;
    flags_calc[FLAG_Z] = (res_data == '0);
    flags_calc[FLAG_C] = c_flag;
    flags_calc[FLAG_V] = v_flag;
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    ainv_d    = ainv_q;
    bneg_d    = bneg_q;
    op_d      = op_q;
    opc_d     = opc_q;
    rd_d      = rd_q;
    wb_en_d   = wb_en_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    flags_d   = flags_q;
    err_d     = err_q;
    if (accept) begin
      opc_d = in_opcode;
      rd_d  = in_rd;
      if (dec_illegal) begin
        err_d     = 1'b1;
        wb_en_d   = 1'b0;
        wb_rd_d   = in_rd;
        wb_data_d = '0;
        flags_d   = 4'd0;
      end else begin
        a_d    = in_a;
        b_d    = in_b;
        ainv_d = dec_ainv;
        bneg_d = dec_bneg;
        op_d   = dec_op;
      end
    end else if (flush_act || release_beat) begin
      a_d       = '0;
      b_d       = '0;
      ainv_d    = 1'b0;
      bneg_d    = 1'b0;
      op_d      = 3'd0;
      opc_d     = 4'd0;
      rd_d      = 3'd0;
      wb_en_d   = 1'b0;
      wb_rd_d   = 3'd0;
      wb_data_d = '0;
      flags_d   = 4'd0;
      err_d     = 1'b0;
    end else if (capture) begin
      a_d       = '0;
      b_d       = '0;
      ainv_d    = 1'b0;
      bneg_d    = 1'b0;
      op_d      = 3'd0;
      wb_en_d   = 1'b1;
      wb_rd_d   = rd_q;
      wb_data_d = res_data;
      flags_d   = flags_calc;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      ainv_q    <= 1'b0;
      bneg_q    <= 1'b0;
      op_q      <= 3'd0;
      opc_q     <= 4'd0;
      rd_q      <= 3'd0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 3'd0;
      wb_data_q <= '0;
      flags_q   <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      ainv_q    <= ainv_d;
      bneg_q    <= bneg_d;
      op_q      <= op_d;
      opc_q     <= opc_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ainvert = ainv_q;
  assign alu_bnegate = bneg_q;
  assign alu_op      = op_q;
  assign wb_en       = wb_en_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign flags       = flags_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural model of the ripple ALU
// hanging off the alu_* lines; expected results are hand-computed constants.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = 4'd0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic [2:0]  in_rd = 3'd0;
  logic        flush = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic        alu_ainvert, alu_bnegate;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [3:0]  flags;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.WIDTH(16), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainvert(alu_ainvert),
    .alu_bnegate(alu_bnegate), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flags(flags), .err(err)
  );

  // Ripple ALU model: per-slice invert, carry-in = Bnegate, op select
  logic [15:0] ma, mb;
  logic [16:0] sum;
  always_comb begin
    ma  = alu_ainvert ? ~alu_a : alu_a;
    mb  = alu_bnegate ? ~alu_b : alu_b;
    sum = {1'b0, ma} + {1'b0, mb} + {16'd0, alu_bnegate};
    case (alu_op)
      3'd0:    alu_result = ma & mb;
      3'd1:    alu_result = ma | mb;
      3'd2:    alu_result = sum[15:0];
      3'd3:    alu_result = ma ^ mb;
      default: alu_result = 16'd0;
    endcase
    alu_cout = sum[16];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one instruction, measures negedges until out_valid, checks the beat, then releases it
  task automatic run_op(input string tag, input logic [3:0] opc, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] rd, input logic fl,
                        input int exp_lat, input logic [15:0] exp_data,
                        input logic [3:0] exp_flags, input logic exp_wb_en, input logic exp_err);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = opc; in_a = a; in_b = b; in_rd = rd; flush = fl;
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      n++;
      if (n == 1 && exp_lat > 1) begin
        chk({tag, ".alu_a"}, 32'(alu_a), 32'(a));
        chk({tag, ".alu_b"}, 32'(alu_b), 32'(b));
      end
    end while (!out_valid && n < 20);
    chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
    chk({tag, ".wb_data"}, 32'(wb_data), 32'(exp_data));
    chk({tag, ".flags"}, 32'(flags), 32'(exp_flags));
    chk({tag, ".wb_en"}, 32'(wb_en), 32'(exp_wb_en));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    if (exp_wb_en) chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.wb_data", 32'(wb_data), 32'd0);
    chk("rst.alu_a", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready_live", 32'(in_ready), 32'd1);

    //      tag     opc    a         b         rd  fl lat data      flags    en  err
    run_op("add_ov",  4'd0, 16'h7FFF, 16'h0001, 3'd1, 0, 3, 16'h8000, 4'b1001, 1, 0);
    run_op("sub_eq",  4'd1, 16'h0005, 16'h0005, 3'd2, 0, 3, 16'h0000, 4'b0110, 1, 0);
    run_op("sub_brw", 4'd1, 16'h0000, 16'h0001, 3'd3, 0, 3, 16'hFFFF, 4'b1000, 1, 0);
    run_op("nor",     4'd5, 16'h00F0, 16'h0F00, 3'd4, 0, 3, 16'hF00F, 4'b1000, 1, 0);
    run_op("slt_t",   4'd7, 16'h8000, 16'h0001, 3'd5, 0, 3, 16'h0001, 4'b0011, 1, 0);
    run_op("slt_f",   4'd7, 16'h0001, 16'h8000, 3'd6, 0, 3, 16'h0000, 4'b1101, 1, 0);
    run_op("and",     4'd2, 16'hF0F0, 16'hFF00, 3'd7, 0, 3, 16'hF000, 4'b1000, 1, 0);
    run_op("or",      4'd3, 16'h0F0F, 16'h00F0, 3'd1, 0, 3, 16'h0FFF, 4'b0000, 1, 0);
    run_op("xor",     4'd4, 16'hAAAA, 16'hFFFF, 3'd2, 0, 3, 16'h5555, 4'b0000, 1, 0);
    run_op("nand",    4'd6, 16'hFFFF, 16'hFFFF, 3'd3, 0, 3, 16'h0000, 4'b0100, 1, 0);
    run_op("add_c",   4'd0, 16'hFFFF, 16'h0001, 3'd4, 0, 3, 16'h0000, 4'b0110, 1, 0);
    run_op("illegal", 4'hA, 16'h1234, 16'h5678, 3'd5, 0, 1, 16'h0000, 4'b0000, 0, 1);
    run_op("idle_fl", 4'd0, 16'h0002, 16'h0003, 3'd6, 1, 3, 16'h0005, 4'b0000, 1, 0);

    // Backpressure: beat held for 5 cycles with out_ready low
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 4'd0; in_a = 16'h1234; in_b = 16'h1111; in_rd = 3'd2;
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 20);
    chk("bp.latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.wb_data", 32'(wb_data), 32'h2345);
      chk("bp.flags", 32'(flags), 32'd0);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.released", 32'(out_valid), 32'd0);

    // Flush while in EXEC: no beat ever appears
    in_valid = 1'b1; in_opcode = 4'd0; in_a = 16'h0001; in_b = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    chk("fl_exec.alu_a", 32'(alu_a), 32'h0001);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_exec.alu_a_clr", 32'(alu_a), 32'd0);
    chk("fl_exec.in_ready", 32'(in_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("fl_exec.no_beat", 32'(n), 32'd0);

    // Flush in DONE wins over out_ready
    in_valid = 1'b1; in_opcode = 4'd3; in_a = 16'h00FF; in_b = 16'hFF00;
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 20);
    chk("fl_done.wb_data", 32'(wb_data), 32'hFFFF);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("fl_done.out_valid", 32'(out_valid), 32'd0);
    chk("fl_done.wb_data_clr", 32'(wb_data), 32'd0);

    // Async reset mid-EXEC
    in_valid = 1'b1; in_opcode = 4'd1; in_a = 16'h0009; in_b = 16'h0004;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_exec.alu_bnegate", 32'(alu_bnegate), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_exec.alu_a", 32'(alu_a), 32'd0);
    chk("rst_exec.alu_bnegate0", 32'(alu_bnegate), 32'd0);
    chk("rst_exec.out_valid", 32'(out_valid), 32'd0);
    chk("rst_exec.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 4'd1, 16'h0009, 16'h0004, 3'd7, 0, 3, 16'h0005, 4'b0010, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
